// File: rtl/fp_pkg.sv
// Shared floating-point constants and FSM state type for the integer
// converter and the FPU datapath blocks that consume its packed operands.
package fp_pkg;

  // Exponent field width for a given float width (single or double).
  function automatic int expo_bits(input int x);
    return (x == 64) ? 11 : 8;
  endfunction

  // Stored fraction width, hidden bit excluded.
  function automatic int mant_bits(input int x);
    return (x == 64) ? 52 : 23;
  endfunction

  // Exponent bias.
  function automatic int bias(input int x);
    return (x == 64) ? 1023 : 127;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } cvt_state_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a truncated fraction. A carry out of the
// fraction bumps the exponent; the fraction is then all zeros, which is
// the correct 1.0 mantissa for the next binade.
module fp_round_rne #(
  parameter int MB = 23,
  parameter int EW = 9
) (
  input  logic [MB-1:0] i_frac,
  input  logic          i_guard,
  input  logic          i_sticky,
  input  logic [EW-1:0] i_exp,
  output logic [MB-1:0] o_frac,
  output logic [EW-1:0] o_exp,
  output logic          o_inexact
);

  logic w_inc;
  logic w_carry;

  assign w_inc              = i_guard & (i_sticky | i_frac[0]);
  assign {w_carry, o_frac}  = {1'b0, i_frac} + (MB+1)'(w_inc);
  assign o_exp              = i_exp + EW'(w_carry);
  assign o_inexact          = i_guard | i_sticky;

endmodule

// File: rtl/int_to_fp.sv
// Signed integer to IEEE-754 converter. Magnitude is normalised one left
// shift per cycle, then rounded to nearest-even in a single cycle.
//
// state   | meaning
// S_IDLE  | waiting for start; operand captured on the accepting edge
// S_NORM  | shifting mag left until its MSB is set (or mag is zero)
// S_ROUND | rounding and packing the result into out/inexact
// S_DONE  | result valid, done pulses for this one cycle
module int_to_fp
  import fp_pkg::*;
#(
  parameter int X = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [X-1:0] in_int,
  output logic [X-1:0] out,
  output logic         done,
  output logic         busy,
  output logic         inexact
);

  localparam int EB   = expo_bits(X);
  localparam int MB   = mant_bits(X);
  localparam int BIAS = bias(X);
  localparam int EW   = EB + 1;
  localparam logic [EW-1:0] EXP_INIT = EW'(X - 1);

  cvt_state_t     r_state;
  cvt_state_t     w_state_nxt;
  logic           r_sign;
  logic [X-1:0]   r_mag;
  logic [EW-1:0]  r_exp_cnt;
  logic [X-1:0]   r_out;
  logic           r_inexact;

  logic [X-1:0]   w_abs;
  logic [MB-1:0]  w_frac_rnd;
  logic [EW-1:0]  w_exp_rnd;
  logic           w_inexact;
  logic [EW-1:0]  w_biased;
  logic           w_unused;

  // Two's-complement magnitude; the most-negative input maps to 2^(X-1).
  assign w_abs = in_int[X-1] ? (~in_int + X'(1)) : in_int;

  fp_round_rne #(
    .MB (MB),
    .EW (EW)
  ) u_round (
    .i_frac    (r_mag[X-2 -: MB]),
    .i_guard   (r_mag[X-2-MB]),
    .i_sticky  (|r_mag[X-3-MB:0]),
    .i_exp     (r_exp_cnt),
    .o_frac    (w_frac_rnd),
    .o_exp     (w_exp_rnd),
    .o_inexact (w_inexact)
  );

  // Unbiased exponent is at most X-1, so the biased value fits in EB bits.
  assign w_biased = w_exp_rnd + EW'(BIAS);
  assign w_unused = w_biased[EW-1];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_nxt = S_NORM;
      end
      S_NORM: begin
        if (r_mag == '0)     w_state_nxt = S_DONE;
        else if (r_mag[X-1]) w_state_nxt = S_ROUND;
      end
      S_ROUND: w_state_nxt = S_DONE;
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, normalise shift, result packing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_exp_cnt <= '0;
      r_out     <= '0;
      r_inexact <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign    <= in_int[X-1];
            r_mag     <= w_abs;
            r_exp_cnt <= EXP_INIT;
          end
        end
        S_NORM: begin
          if (r_mag == '0) begin
            r_out     <= '0;
            r_inexact <= 1'b0;
          end else if (!r_mag[X-1]) begin
            r_mag     <= r_mag << 1;
            r_exp_cnt <= r_exp_cnt - EW'(1);
          end
        end
        S_ROUND: begin
          r_out     <= {r_sign, w_biased[EB-1:0], w_frac_rnd};
          r_inexact <= w_inexact;
        end
        default: ;
      endcase
    end
  end

  assign out     = r_out;
  assign inexact = r_inexact;

endmodule

// File: tb/tb_int_to_fp.sv
// Bench for int_to_fp: table of conversions through a scoreboard for the
// 32-bit instance, hand sequences for handshake/reset corners, and a few
// 64-bit conversions on a second instance.
module tb_int_to_fp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] in_int = '0;
  logic [31:0] out32;
  logic        done, busy, inexact;

  logic        start64 = 1'b0;
  logic [63:0] in64 = '0;
  logic [63:0] out64;
  logic        done64, busy64, inexact64;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  typedef struct {
    logic [31:0] in;
    logic [31:0] out;
    logic        inx;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] out;
    logic        inx;
    int          lat;
    int          acc;
  } sb_t;

  typedef struct {
    logic [63:0] in;
    logic [63:0] out;
    logic        inx;
    int          lat;
  } vec64_t;

  vec_t   vecs[15];
  vec64_t v64[3];
  sb_t    sbq[$];

  int_to_fp #(.X(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_int(in_int),
    .out(out32), .done(done), .busy(busy), .inexact(inexact)
  );

  int_to_fp #(.X(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .in_int(in64),
    .out(out64), .done(done64), .busy(busy64), .inexact(inexact64)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      sb_t e;
      done_cnt++;
      chk("done_width", {63'd0, prev_done}, 64'd0);
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done with out %h, expected no done", out32);
      end else begin
        e = sbq.pop_front();
        chk("out", {32'd0, out32}, {32'd0, e.out});
        chk("inexact", {63'd0, inexact}, {63'd0, e.inx});
        chk("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
    prev_done <= done;
  end

  task automatic convert(input logic [31:0] v, input logic [31:0] eo, input logic ei, input int lat);
    sb_t e;
    int i;
    @(negedge clk);
    for (i = 0; i < 200 && busy; i++) @(negedge clk);
    if (busy) begin
      n_total++;
      $display("FAIL idle_timeout: busy still %b, expected 0", busy);
    end
    start  = 1'b1;
    in_int = v;
    @(negedge clk);
    start  = 1'b0;
    in_int = 32'hDEADBEEF;
    e.out = eo; e.inx = ei; e.lat = lat; e.acc = cyc;
    sbq.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0 && !busy) return;
      @(negedge clk);
    end
    n_total++;
    $display("FAIL drain_timeout: %0d results outstanding, expected 0", sbq.size());
  endtask

  initial begin
    int base_done;
    vecs[0]  = '{32'h00000001, 32'h3F800000, 1'b0, 34};
    vecs[1]  = '{32'hFFFFFFFF, 32'hBF800000, 1'b0, 34};
    vecs[2]  = '{32'h00000000, 32'h00000000, 1'b0, 2};
    vecs[3]  = '{32'h80000000, 32'hCF000000, 1'b0, 3};
    vecs[4]  = '{32'h01000001, 32'h4B800000, 1'b1, 10};
    vecs[5]  = '{32'h01000003, 32'h4B800002, 1'b1, 10};
    vecs[6]  = '{32'h7FFFFFFF, 32'h4F000000, 1'b1, 4};
    vecs[7]  = '{32'h00000002, 32'h40000000, 1'b0, 33};
    vecs[8]  = '{32'd100,      32'h42C80000, 1'b0, 28};
    vecs[9]  = '{32'hFFFFFF00, 32'hC3800000, 1'b0, 26};
    vecs[10] = '{32'h01000002, 32'h4B800001, 1'b0, 10};
    vecs[11] = '{32'h01000005, 32'h4B800002, 1'b1, 10};
    vecs[12] = '{32'h01000007, 32'h4B800004, 1'b1, 10};
    vecs[13] = '{32'h00FFFFFF, 32'h4B7FFFFF, 1'b0, 11};
    vecs[14] = '{32'hFEFFFFFD, 32'hCB800002, 1'b1, 10};

    v64[0] = '{64'hFFFFFFFFFFFFFFFD, 64'hC008000000000000, 1'b0, 65};
    v64[1] = '{64'h0000000000000001, 64'h3FF0000000000000, 1'b0, 66};
    v64[2] = '{64'h0020000000000001, 64'h4340000000000000, 1'b1, 13};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out", {32'd0, out32}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_inexact", {63'd0, inexact}, 64'd0);
    rst_n = 1'b1;

    // Table: issued back-to-back as soon as the converter is idle.
    foreach (vecs[k]) convert(vecs[k].in, vecs[k].out, vecs[k].inx, vecs[k].lat);
    drain();

    // Start pulsed mid-conversion must be ignored.
    base_done = done_cnt;
    convert(32'h00000001, 32'h3F800000, 1'b0, 34);
    repeat (5) @(negedge clk);
    start = 1'b1; in_int = 32'h00000005;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    chk("mid_start_one_done", 64'(done_cnt - base_done), 64'd1);

    // Start seen only in the DONE cycle must be ignored.
    convert(32'h00000003, 32'h40400000, 1'b0, 33);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    start = 1'b1; in_int = 32'h00000009;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_ignored", {63'd0, busy}, 64'd0);
    drain();

    // Reset during NORM discards the conversion silently.
    base_done = done_cnt;
    @(negedge clk);
    start = 1'b1; in_int = 32'h00000001;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_out", {32'd0, out32}, 64'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt - base_done), 64'd0);
    convert(32'h7FFFFFFF, 32'h4F000000, 1'b1, 4);
    drain();

    // Double precision.
    foreach (v64[k]) begin
      int acc;
      int i;
      @(negedge clk);
      start64 = 1'b1; in64 = v64[k].in;
      @(negedge clk);
      start64 = 1'b0;
      acc = cyc;
      for (i = 0; i < 100 && !done64; i++) @(negedge clk);
      if (!done64) begin
        n_total++;
        $display("FAIL x64_done_timeout: done64 %b, expected 1", done64);
      end else begin
        chk("x64_out", out64, v64[k].out);
        chk("x64_inexact", {63'd0, inexact64}, {63'd0, v64[k].inx});
        chk("x64_latency", 64'(cyc - acc + 1), 64'(v64[k].lat));
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
